// File: rtl/cy_sync_edge_status_v1_0_pkg.sv
// Shared encodings and helpers for the synchronized edge-status block.
// Edge-mode values match the legacy CY_EDGE_* defines used by the status register firmware.
package cy_sync_edge_status_v1_0_pkg;

   localparam logic [1:0] CY_EDGE_RISE = 2'd0;
   localparam logic [1:0] CY_EDGE_FALL = 2'd1;
   localparam logic [1:0] CY_EDGE_BOTH = 2'd2;

   // A zero-cycle debounce still needs a legal one-bit counter declaration.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   function automatic logic edge_qualify(input logic [1:0] mode, input logic prev, input logic next);
      case (mode)
         CY_EDGE_RISE: return !prev && next;
         CY_EDGE_FALL: return prev && !next;
         default:      return prev != next;
      endcase
   endfunction

endpackage

// File: rtl/cy_sync_edge_status_v1_0_debounce_bit.sv
// One debounced input bit: mismatch counter, accepted-level flop and an
// edge event that fires in the same cycle the level is about to change.
module cy_debounce_bit
   import cy_sync_edge_status_v1_0_pkg::*;
#(
   parameter int DebounceCycles = 4,
   parameter int EdgeMode       = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sample,
   output logic level,
   output logic evt
);

   localparam int            CW   = cnt_width(DebounceCycles);
   localparam logic [CW-1:0] LAST = CW'((DebounceCycles > 0) ? DebounceCycles - 1 : 0);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          level_next;

   // A single matching sample restarts the count, so short glitches never reach LAST.
   always_comb begin
      count_next = '0;
      level_next = level;
      if (DebounceCycles == 0) begin
         level_next = sample;
      end else if (sample != level) begin
         if (count == LAST) begin
            level_next = sample;
         end else begin
            count_next = count + 1'b1;
         end
      end
   end

   assign evt = edge_qualify(2'(EdgeMode), level, level_next);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         level <= 1'b0;
      end else begin
         count <= count_next;
         level <= level_next;
      end
   end

endmodule

// File: rtl/cy_sync_edge_status_v1_0.sv
// Debounced edge detector with clear-on-read sticky status and a maskable,
// registered interrupt for the UDB status register / ISR path.
module cy_sync_edge_status_v1_0
   import cy_sync_edge_status_v1_0_pkg::*;
#(
   parameter int SignalWidth    = 1,
   parameter int DebounceCycles = 4,
   parameter int EdgeMode       = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [SignalWidth-1:0] s_in,
   input  logic [SignalWidth-1:0] int_mask,
   input  logic                   status_rd,
   output logic [SignalWidth-1:0] level,
   output logic [SignalWidth-1:0] status,
   output logic                   interrupt
);

   logic [SignalWidth-1:0] evt;
   logic [SignalWidth-1:0] status_next;

   for (genvar i = 0; i < SignalWidth; i++) begin : g_bit
      cy_debounce_bit #(
         .DebounceCycles(DebounceCycles),
         .EdgeMode      (EdgeMode)
      ) u_bit (
         .clock  (clock),
         .reset_n(reset_n),
         .sample (s_in[i]),
         .level  (level[i]),
         .evt    (evt[i])
      );
   end

   // A new event wins over a coincident read so no edge is ever lost.
   assign status_next = evt | (status & ~{SignalWidth{status_rd}});

   // Interrupt follows the registered status, one clock behind it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status    <= '0;
         interrupt <= 1'b0;
      end else begin
         status    <= status_next;
         interrupt <= |(status & int_mask);
      end
   end

endmodule

// File: tb/tb_cy_sync_edge_status_v1_0.sv
// Scoreboard bench: several parameterisations share one stimulus stream and are
// checked against a history-based reference model of the debounce/status rules.
module tb_cy_sync_edge_status_v1_0;

   localparam int NCFG = 5;
   localparam int DCS [NCFG] = '{4, 4, 4, 0, 1};
   localparam int EMS [NCFG] = '{0, 1, 2, 2, 2};

   typedef struct packed {
      logic [NCFG-1:0][1:0] lvl;
      logic [NCFG-1:0][1:0] st;
      logic [NCFG-1:0]      irq;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] s_in;
   logic [1:0] int_mask;
   logic       status_rd;

   logic [1:0] lvl_o [NCFG];
   logic [1:0] st_o  [NCFG];
   logic       irq_o [NCFG];

   logic [1:0] mlv  [NCFG];
   logic [1:0] mst  [NCFG];
   logic       mirq [NCFG];
   logic [7:0] hist [NCFG][2];

   exp_t scoreboard [$];
   int   checks = 0;
   int   passes = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      cy_sync_edge_status_v1_0 #(
         .SignalWidth   (2),
         .DebounceCycles(DCS[g]),
         .EdgeMode      (EMS[g])
      ) dut (
         .clock    (clock),
         .reset_n  (reset_n),
         .s_in     (s_in),
         .int_mask (int_mask),
         .status_rd(status_rd),
         .level    (lvl_o[g]),
         .status   (st_o[g]),
         .interrupt(irq_o[g])
      );
   end

   task automatic checkOutput(input string name, input int k, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp)
         $display("[TB] FAIL %s cfg%0d t=%0t actual=%b expected=%b", name, k, $time, act, exp);
      else
         passes++;
   endtask

   // Reference model: a level flips once the last DebounceCycles samples all disagree with it.
   task automatic modelStep();
      for (int k = 0; k < NCFG; k++) begin
         if (!reset_n) begin
            mlv[k]  = '0;
            mst[k]  = '0;
            mirq[k] = 1'b0;
            for (int b = 0; b < 2; b++) hist[k][b] = '0;
         end else begin
            logic newirq;
            newirq = |(mst[k] & int_mask);
            for (int b = 0; b < 2; b++) begin
               logic nl, evt, all_diff;
               hist[k][b] = {hist[k][b][6:0], s_in[b]};
               if (DCS[k] == 0) begin
                  nl = s_in[b];
               end else begin
                  all_diff = 1'b1;
                  for (int j = 0; j < DCS[k]; j++)
                     if (hist[k][b][j] == mlv[k][b]) all_diff = 1'b0;
                  nl = all_diff ? ~mlv[k][b] : mlv[k][b];
               end
               evt = (nl != mlv[k][b]) &&
                     ((EMS[k] == 2) || (EMS[k] == 0 && nl) || (EMS[k] == 1 && !nl));
               mst[k][b] = evt | (mst[k][b] & ~status_rd);
               mlv[k][b] = nl;
            end
            mirq[k] = newirq;
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] s, input logic [1:0] m, input logic rd,
                                input logic rst, input int n);
      repeat (n) begin
         exp_t e;
         logic prev_rst;
         @(negedge clock);
         prev_rst  = reset_n;
         s_in      = s;
         int_mask  = m;
         status_rd = rd;
         reset_n   = rst;
         modelStep();
         for (int k = 0; k < NCFG; k++) begin
            e.lvl[k] = mlv[k];
            e.st[k]  = mst[k];
            e.irq[k] = mirq[k];
         end
         scoreboard.push_back(e);
         if (prev_rst && !rst) begin
            #1;
            for (int k = 0; k < NCFG; k++) begin
               checkOutput("async_reset_level", k, lvl_o[k], 2'b00);
               checkOutput("async_reset_status", k, st_o[k], 2'b00);
               checkOutput("async_reset_irq", k, {1'b0, irq_o[k]}, 2'b00);
            end
         end
      end
   endtask

   // Monitor: every clock the DUTs present a new output set, compared against the queue head.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (scoreboard.size() > 0) begin
            exp_t e;
            e = scoreboard.pop_front();
            for (int k = 0; k < NCFG; k++) begin
               checkOutput("level", k, lvl_o[k], e.lvl[k]);
               checkOutput("status", k, st_o[k], e.st[k]);
               checkOutput("interrupt", k, {1'b0, irq_o[k]}, {1'b0, e.irq[k]});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] s;
      logic [1:0] m;
      int         hold [2];
      reset_n   = 1'b0;
      s_in      = '0;
      int_mask  = 2'b01;
      status_rd = 1'b0;
      for (int k = 0; k < NCFG; k++) begin
         mlv[k] = '0; mst[k] = '0; mirq[k] = 1'b0;
         hist[k][0] = '0; hist[k][1] = '0;
      end

      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 3);
      // rising step on bit 0, then falling step
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b1, 8);
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b1, 8);
      applyStimulus(2'b00, 2'b01, 1'b1, 1'b1, 1);
      // three-cycle glitch must be dropped by the 4-cycle configs
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b1, 3);
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b1, 6);
      // read-clear with and without a coincident event on bit 1
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b1, 6);
      applyStimulus(2'b01, 2'b01, 1'b1, 1'b1, 1);
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b1, 3);
      applyStimulus(2'b11, 2'b01, 1'b0, 1'b1, 3);
      applyStimulus(2'b11, 2'b01, 1'b1, 1'b1, 1);
      applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 4);
      // reset mid-count with status pending, then re-debounce from level 0
      applyStimulus(2'b00, 2'b11, 1'b0, 1'b1, 6);
      applyStimulus(2'b01, 2'b11, 1'b0, 1'b1, 2);
      applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 2);
      applyStimulus(2'b01, 2'b11, 1'b0, 1'b1, 6);
      // toggle every cycle: only the bypass configs follow
      for (int i = 0; i < 10; i++)
         applyStimulus((i % 2) ? 2'b10 : 2'b01, 2'b11, 1'b0, 1'b1, 1);
      applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 3);

      // randomized hold lengths, reads, mask changes and occasional resets
      s       = 2'b00;
      m       = 2'b11;
      hold[0] = 1;
      hold[1] = 1;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 2; b++) begin
            hold[b]--;
            if (hold[b] <= 0) begin
               s[b]    = ~s[b];
               hold[b] = $urandom_range(1, 7);
            end
         end
         if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0)
            applyStimulus(s, m, 1'b0, 1'b0, 2);
         else
            applyStimulus(s, m, ($urandom_range(0, 3) == 0), 1'b1, 1);
      end

      @(posedge clock);
      #3;
      checks++;
      if (scoreboard.size() != 0)
         $display("[TB] FAIL scoreboard_drain actual=%0d required=0", scoreboard.size());
      else
         passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
